sobel_row_buffer: RTL and testbench



---
 rtl/sobel_row_buffer_pkg.sv | 16 +
 rtl/sobel_row_buffer.sv | 119 +++++++++++
 tb/tb_sobel_row_buffer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_row_buffer_pkg.sv
// Shared widths and FSM encoding for the Sobel row buffer.
// A row segment holds NUM_SOBEL_ACCELERATORS+2 eight-bit pixels.
package sobel_row_buffer_pkg;

   localparam int NUM_SOBEL_ACCELERATORS = 4;
   localparam int SOBEL_IDATA_WIDTH      = (NUM_SOBEL_ACCELERATORS + 2) * 8;
   localparam int SOBEL_CNT_WIDTH        = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } srow_state_t;

endpackage

// File: rtl/sobel_row_buffer.sv
// Three-row sliding window between the row fetcher and the Sobel accelerator core.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module sobel_row_buffer
   import sobel_row_buffer_pkg::*;
#(
   parameter int ROW_WIDTH = SOBEL_IDATA_WIDTH,
   parameter int CNT_WIDTH = SOBEL_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 frame_start,
   input  logic [CNT_WIDTH-1:0] frame_rows,
   input  logic                 mem2srow_valid,
   input  logic [ROW_WIDTH-1:0] mem2srow_data,
   output logic                 srow2mem_ready,
   output logic [ROW_WIDTH-1:0] srow2sacc_row1_data,
   output logic [ROW_WIDTH-1:0] srow2sacc_row2_data,
   output logic [ROW_WIDTH-1:0] srow2sacc_row3_data,
   output logic                 srow2sacc_valid,
   input  logic                 sacc2srow_ready,
   output logic                 srow2sacc_last,
   output logic                 frame_done,
   output logic                 frame_err,
   output srow_state_t          fsm_state
);

   srow_state_t          state_q;
   logic [CNT_WIDTH-1:0] rows_q;
   logic [CNT_WIDTH-1:0] rows_in;
   logic [CNT_WIDTH-1:0] win_out;
   logic [ROW_WIDTH-1:0] row1_q, row2_q, row3_q;
   logic                 valid_q;
   logic                 in_fire;
   logic                 out_fire;

   // Ready looks at the downstream ready so a consume and an accept can share
   // one edge; it never depends on mem2srow_valid.
   assign srow2mem_ready = (state_q == ST_FILL) ||
                           ((state_q == ST_STREAM) && (rows_in < rows_q) &&
                            (!valid_q || sacc2srow_ready));

   assign in_fire             = mem2srow_valid && srow2mem_ready;
   assign out_fire            = valid_q && sacc2srow_ready;
   assign srow2sacc_valid     = valid_q;
   assign srow2sacc_last      = valid_q && (win_out == rows_q - CNT_WIDTH'(3));
   assign srow2sacc_row1_data = row1_q;
   assign srow2sacc_row2_data = row2_q;
   assign srow2sacc_row3_data = row3_q;
   assign fsm_state           = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row1_q <= '0;
         row2_q <= '0;
         row3_q <= '0;
      end else if (in_fire) begin
         row1_q <= row2_q;
         row2_q <= row3_q;
         row3_q <= mem2srow_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         rows_q     <= '0;
         rows_in    <= '0;
         win_out    <= '0;
         valid_q    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (frame_start) begin
                  if (frame_rows >= CNT_WIDTH'(3)) begin
                     rows_q  <= frame_rows;
                     rows_in <= '0;
                     win_out <= '0;
                     state_q <= ST_FILL;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (in_fire) begin
                  rows_in <= rows_in + CNT_WIDTH'(1);
                  if (rows_in == CNT_WIDTH'(2)) begin
                     state_q <= ST_STREAM;
                     valid_q <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (in_fire) rows_in <= rows_in + CNT_WIDTH'(1);
               if (out_fire) begin
                  win_out <= win_out + CNT_WIDTH'(1);
                  if (srow2sacc_last) begin
                     state_q    <= ST_DONE;
                     frame_done <= 1'b1;
                     valid_q    <= 1'b0;
                  end else begin
                     valid_q <= in_fire;
                  end
               end else if (in_fire) begin
                  valid_q <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_row_buffer.sv
// Bench for sobel_row_buffer: windows are predicted from the list of accepted rows
// and the count of windows consumed, compared on every cycle.
module tb_sobel_row_buffer;
   import sobel_row_buffer_pkg::*;

   localparam int W  = SOBEL_IDATA_WIDTH;
   localparam int CW = SOBEL_CNT_WIDTH;

   logic          clk;
   logic          reset_n;
   logic          frame_start;
   logic [CW-1:0] frame_rows;
   logic          mem2srow_valid;
   logic [W-1:0]  mem2srow_data;
   logic          srow2mem_ready;
   logic [W-1:0]  srow2sacc_row1_data;
   logic [W-1:0]  srow2sacc_row2_data;
   logic [W-1:0]  srow2sacc_row3_data;
   logic          srow2sacc_valid;
   logic          sacc2srow_ready;
   logic          srow2sacc_last;
   logic          frame_done;
   logic          frame_err;
   srow_state_t   fsm_state;

   sobel_row_buffer #(.ROW_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .frame_start         (frame_start),
      .frame_rows          (frame_rows),
      .mem2srow_valid      (mem2srow_valid),
      .mem2srow_data       (mem2srow_data),
      .srow2mem_ready      (srow2mem_ready),
      .srow2sacc_row1_data (srow2sacc_row1_data),
      .srow2sacc_row2_data (srow2sacc_row2_data),
      .srow2sacc_row3_data (srow2sacc_row3_data),
      .srow2sacc_valid     (srow2sacc_valid),
      .sacc2srow_ready     (sacc2srow_ready),
      .srow2sacc_last      (srow2sacc_last),
      .frame_done          (frame_done),
      .frame_err           (frame_err),
      .fsm_state           (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_errors = 0;
   int m_phase  = 0;   // 0 idle, 1 frame active, 2 frame finishing
   int m_n      = 0;
   int m_in     = 0;
   int m_win    = 0;
   bit m_err    = 1'b0;
   bit m_done   = 1'b0;
   int dut_wins = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_row();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // ---------------- driver: one cycle, compare, advance model ----------------
   task automatic step(input bit fs, input int nr, input bit v, input logic [W-1:0] d, input bit r);
      bit e_valid, e_ready, e_last, in_f, out_f, nxt_err, nxt_done;
      @(negedge clk);
      frame_start     = fs;
      frame_rows      = CW'(nr);
      mem2srow_valid  = v;
      mem2srow_data   = d;
      sacc2srow_ready = r;
      #1;
      e_valid = (m_phase == 1) && (m_in >= m_win + 3);
      e_ready = (m_phase == 1) && (m_in < m_n) && (!e_valid || r);
      e_last  = e_valid && (m_win == m_n - 3);
      chk("ready", 64'(srow2mem_ready), 64'(e_ready));
      chk("valid", 64'(srow2sacc_valid), 64'(e_valid));
      chk("last", 64'(srow2sacc_last), 64'(e_last));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("frame_err", 64'(frame_err), 64'(m_err));
      if (e_valid) begin
         chk("row1", 64'(srow2sacc_row1_data), 64'(exp_q[m_win]));
         chk("row2", 64'(srow2sacc_row2_data), 64'(exp_q[m_win + 1]));
         chk("row3", 64'(srow2sacc_row3_data), 64'(exp_q[m_win + 2]));
      end
      if (srow2sacc_valid && sacc2srow_ready) dut_wins++;
      in_f     = v && e_ready;
      out_f    = e_valid && r;
      nxt_err  = 1'b0;
      nxt_done = 1'b0;
      case (m_phase)
         0: if (fs) begin
            if (nr >= 3) begin
               m_phase = 1; m_n = nr; m_in = 0; m_win = 0;
               exp_q.delete();
            end else begin
               nxt_err = 1'b1;
            end
         end
         1: begin
            if (in_f) begin exp_q.push_back(d); m_in++; end
            if (out_f) begin
               m_win++;
               if (m_win == m_n - 2) begin m_phase = 2; nxt_done = 1'b1; end
            end
         end
         default: m_phase = 0;
      endcase
      m_err  = nxt_err;
      m_done = nxt_done;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ready"}, 64'(srow2mem_ready), 64'd0);
      chk({tag, "_valid"}, 64'(srow2sacc_valid), 64'd0);
      chk({tag, "_last"}, 64'(srow2sacc_last), 64'd0);
      chk({tag, "_done"}, 64'(frame_done), 64'd0);
      chk({tag, "_err"}, 64'(frame_err), 64'd0);
      chk({tag, "_row1"}, 64'(srow2sacc_row1_data), 64'd0);
      chk({tag, "_row2"}, 64'(srow2sacc_row2_data), 64'd0);
      chk({tag, "_row3"}, 64'(srow2sacc_row3_data), 64'd0);
      chk({tag, "_state"}, 64'(fsm_state), 64'(ST_IDLE));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      frame_start = 1'b0; mem2srow_valid = 1'b0; sacc2srow_ready = 1'b0;
      #1;
      check_zero_outputs("reset");
      m_phase = 0; m_in = 0; m_win = 0; m_err = 1'b0; m_done = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Runs until the model is idle again; optional stray frame_start pulses mid-frame.
   task automatic run_frame(input int n, input int vpct, input int rpct, input bit inject);
      int c;
      bit fs;
      dut_wins = 0;
      step(1'b1, n, ($urandom_range(1, 100) <= vpct), rnd_row(), ($urandom_range(1, 100) <= rpct));
      c = 0;
      while ((m_phase != 0 || m_done || m_err) && c < 4000) begin
         fs = inject && ($urandom_range(0, 9) == 0);
         step(fs, $urandom_range(0, 30), ($urandom_range(1, 100) <= vpct), rnd_row(),
              ($urandom_range(1, 100) <= rpct));
         c++;
      end
      if (c >= 4000) chk("frame_timeout", 64'd1, 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hold;
      bit seen;
      reset_n = 1'b0; frame_start = 1'b0; frame_rows = '0;
      mem2srow_valid = 1'b0; mem2srow_data = '0; sacc2srow_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_zero_outputs("por");
      @(negedge clk);
      reset_n = 1'b1;

      // Five rows, no stalls: fill 3 cycles, then 3 back-to-back windows.
      dut_wins = 0;
      step(1'b1, 5, 1'b1, W'(48'hA00), 1'b1);
      for (int t = 1; t <= 8; t++) begin
         step(1'b0, 5, 1'b1, W'(48'hA00 + t), 1'b1);
         if (t == 3) chk("lit_fill_valid", 64'(srow2sacc_valid), 64'd0);
         if (t == 4) begin
            chk("lit_w0_valid", 64'(srow2sacc_valid), 64'd1);
            chk("lit_w0_row1", 64'(srow2sacc_row1_data), 64'hA01);
            chk("lit_w0_row3", 64'(srow2sacc_row3_data), 64'hA03);
            chk("lit_w0_last", 64'(srow2sacc_last), 64'd0);
         end
         if (t == 6) begin
            chk("lit_w2_row1", 64'(srow2sacc_row1_data), 64'hA03);
            chk("lit_w2_row3", 64'(srow2sacc_row3_data), 64'hA05);
            chk("lit_w2_last", 64'(srow2sacc_last), 64'd1);
         end
         if (t == 7) chk("lit_done", 64'(frame_done), 64'd1);
      end
      chk("lit_wins_5", 64'(dut_wins), 64'd3);

      // Four rows with the consumer stalled for 4 cycles after the first window.
      dut_wins = 0;
      hold = 0; seen = 1'b0;
      step(1'b1, 4, 1'b1, rnd_row(), 1'b1);
      for (int c = 0; c < 40 && (m_phase != 0 || m_done); c++) begin
         if (!seen && m_phase == 1 && m_in >= 3) begin seen = 1'b1; hold = 4; end
         step(1'b0, 9, 1'b1, rnd_row(), (hold == 0));
         if (hold > 0) begin
            chk("lit_stall_ready", 64'(srow2mem_ready), 64'd0);
            hold--;
         end
      end
      chk("lit_wins_4", 64'(dut_wins), 64'd2);

      // Two-row frame is rejected.
      step(1'b1, 2, 1'b1, rnd_row(), 1'b1);
      step(1'b0, 2, 1'b1, rnd_row(), 1'b1);
      chk("lit_err_pulse", 64'(frame_err), 64'd1);
      chk("lit_err_state", 64'(fsm_state), 64'(ST_IDLE));
      step(1'b0, 2, 1'b1, rnd_row(), 1'b1);

      // Reset in the middle of a six-row frame, then a clean three-row frame.
      step(1'b1, 6, 1'b1, rnd_row(), 1'b0);
      for (int c = 0; c < 40 && m_in < 4; c++) step(1'b0, 6, 1'b1, rnd_row(), 1'b0);
      do_reset();
      run_frame(3, 100, 100, 1'b0);
      chk("lit_wins_3", 64'(dut_wins), 64'd1);

      // Twenty rows under random stalls with stray frame_start pulses.
      run_frame(20, 70, 60, 1'b1);
      chk("lit_wins_20", 64'(dut_wins), 64'd18);

      for (int f = 0; f < 8; f++) begin
         run_frame($urandom_range(0, 12), $urandom_range(40, 100), $urandom_range(40, 100), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
